// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: issues paired (8-byte) fetches, buffers returned pairs
// in a small FIFO and presents the head pair to decode, with branch redirect/flush.
module instruction_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic [63:0] imemData,
  output logic        valid_ID,
  output logic [31:0] instr1_ID,
  output logic [31:0] instr2_ID,
  output logic [31:0] pc_ID
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h4020_0000;

  logic [31:0] pc_q, pc_d;
  logic        infl_q, infl_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic        infl_nop_q, infl_nop_d;
  logic        nop_pend_q, nop_pend_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [63:0] pair_q [DEPTH];
  logic [31:0] pcs_q  [DEPTH];

  logic [CW:0]  used;
  logic         push, pop;
  logic [63:0]  push_pair;
  logic         unused_tgt;

  assign unused_tgt = ^branchTarget[1:0];

  // Space is reserved at request time, so the in-flight pair always has a slot.
  assign used     = {1'b0, cnt_q} + {{CW{1'b0}}, infl_q};
  assign imemReq  = !reset && !branchTaken && (used < (CW+1)'(DEPTH));
  assign imemAddr = pc_q;

  assign valid_ID  = !reset && (cnt_q != '0);
  assign push      = infl_q && !branchTaken && !reset;
  assign pop       = valid_ID && !stall && !branchTaken;
  assign push_pair = infl_nop_q ? {NOP, imemData[31:0]} : imemData;

  assign instr1_ID = valid_ID ? pair_q[rd_q][63:32] : '0;
  assign instr2_ID = valid_ID ? pair_q[rd_q][31:0]  : '0;
  assign pc_ID     = valid_ID ? pcs_q[rd_q]         : '0;

  always_comb begin
    pc_d       = pc_q;
    infl_d     = 1'b0;
    infl_pc_d  = infl_pc_q;
    infl_nop_d = infl_nop_q;
    nop_pend_d = nop_pend_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    if (branchTaken) begin
      // Flush wins over any push/pop this cycle; a mid-pair target fetches the
      // whole pair and later replaces its even slot with a nop.
      pc_d       = {branchTarget[31:3], 3'b000};
      nop_pend_d = branchTarget[2];
      wr_d       = '0;
      rd_d       = '0;
      cnt_d      = '0;
    end else begin
      if (imemReq) begin
        pc_d       = pc_q + 32'd8;
        infl_d     = 1'b1;
        infl_pc_d  = pc_q;
        infl_nop_d = nop_pend_q;
        nop_pend_d = 1'b0;
      end
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      infl_q     <= 1'b0;
      infl_pc_q  <= '0;
      infl_nop_q <= 1'b0;
      nop_pend_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      infl_q     <= infl_d;
      infl_pc_q  <= infl_pc_d;
      infl_nop_q <= infl_nop_d;
      nop_pend_q <= nop_pend_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pair_q[wr_q] <= push_pair;
      pcs_q[wr_q]  <= infl_pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue; memory returns {addr, ~addr}
// for the address requested in the previous cycle.
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        reset, stall, branchTaken;
  logic [31:0] branchTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [63:0] imemData;
  logic        valid_ID;
  logic [31:0] instr1_ID, instr2_ID, pc_ID;
  logic [31:0] last_addr = '0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  instruction_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemData(imemData), .valid_ID(valid_ID), .instr1_ID(instr1_ID),
    .instr2_ID(instr2_ID), .pc_ID(pc_ID)
  );

  always #5 clk = ~clk;

  always @(posedge clk) last_addr <= imemAddr;
  assign imemData = {last_addr, ~last_addr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic cycle(input logic s, input logic b, input logic [31:0] t);
    @(posedge clk); #1;
    reset = 1'b0; stall = s; branchTaken = b; branchTarget = t;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; stall = 1'b0; branchTaken = 1'b1; branchTarget = 32'h500;
    #1;
    check("rst_req", {31'b0, imemReq}, 32'd0);
    @(posedge clk); #1;
    branchTaken = 1'b0;
    #1;
    check("rst_valid", {31'b0, valid_ID}, 32'd0);
    check("rst_pc", pc_ID, 32'd0);
    check("rst_i1", instr1_ID, 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0;

    // Free-running stream after reset
    do_reset();
    cycle(0, 0, 0);
    check("s0_req", {31'b0, imemReq}, 32'd1);
    check("s0_addr", imemAddr, 32'h0);
    check("s0_valid", {31'b0, valid_ID}, 32'd0);
    cycle(0, 0, 0);
    check("s1_addr", imemAddr, 32'h8);
    check("s1_valid", {31'b0, valid_ID}, 32'd0);
    cycle(0, 0, 0);
    check("s2_valid", {31'b0, valid_ID}, 32'd1);
    check("s2_pc", pc_ID, 32'h0);
    check("s2_i1", instr1_ID, 32'h0);
    check("s2_i2", instr2_ID, 32'hFFFF_FFFF);
    check("s2_addr", imemAddr, 32'h10);
    cycle(0, 0, 0);
    check("s3_pc", pc_ID, 32'h8);
    check("s3_i2", instr2_ID, 32'hFFFF_FFF7);

    // Stall from cycle 0: fill, then drain
    do_reset();
    for (int c = 0; c < 4; c++) begin
      cycle(1, 0, 0);
      check("st_req", {31'b0, imemReq}, 32'd1);
      check("st_addr", imemAddr, 32'(c * 8));
    end
    cycle(1, 0, 0);
    check("st4_req", {31'b0, imemReq}, 32'd0);
    cycle(1, 0, 0);
    check("st5_req", {31'b0, imemReq}, 32'd0);
    check("st5_pc", pc_ID, 32'h0);
    cycle(0, 0, 0);
    check("st6_pc", pc_ID, 32'h0);
    check("st6_req", {31'b0, imemReq}, 32'd0);
    cycle(0, 0, 0);
    check("st7_pc", pc_ID, 32'h8);
    check("st7_req", {31'b0, imemReq}, 32'd1);
    check("st7_addr", imemAddr, 32'h20);
    cycle(0, 0, 0);
    check("st8_pc", pc_ID, 32'h10);
    check("st8_addr", imemAddr, 32'h28);
    cycle(0, 0, 0);
    check("st9_pc", pc_ID, 32'h18);
    cycle(0, 0, 0);
    check("st10_pc", pc_ID, 32'h20);
    check("st10_i1", instr1_ID, 32'h20);

    // Full queue, stalled, redirect to mid-pair target 0x104
    do_reset();
    for (int c = 0; c < 6; c++) cycle(1, 0, 0);
    check("br_full_req", {31'b0, imemReq}, 32'd0);
    cycle(1, 1, 32'h104);
    check("br_req_at_br", {31'b0, imemReq}, 32'd0);
    cycle(1, 0, 0);
    check("br1_valid", {31'b0, valid_ID}, 32'd0);
    check("br1_req", {31'b0, imemReq}, 32'd1);
    check("br1_addr", imemAddr, 32'h100);
    cycle(1, 0, 0);
    check("br2_valid", {31'b0, valid_ID}, 32'd0);
    check("br2_addr", imemAddr, 32'h108);
    cycle(0, 0, 0);
    check("br3_valid", {31'b0, valid_ID}, 32'd1);
    check("br3_pc", pc_ID, 32'h100);
    check("br3_i1", instr1_ID, 32'h4020_0000);
    check("br3_i2", instr2_ID, 32'hFFFF_FEFF);
    cycle(0, 0, 0);
    check("br4_pc", pc_ID, 32'h108);
    check("br4_i1", instr1_ID, 32'h108);

    // Redirect in the cycle the first pair returns
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 1, 32'h200);
    check("rd_req_at_br", {31'b0, imemReq}, 32'd0);
    cycle(0, 0, 0);
    check("rd1_valid", {31'b0, valid_ID}, 32'd0);
    check("rd1_addr", imemAddr, 32'h200);
    cycle(0, 0, 0);
    check("rd2_valid", {31'b0, valid_ID}, 32'd0);
    cycle(0, 0, 0);
    check("rd3_valid", {31'b0, valid_ID}, 32'd1);
    check("rd3_pc", pc_ID, 32'h200);
    check("rd3_i1", instr1_ID, 32'h200);

    // Reset mid-stream with three entries queued
    do_reset();
    for (int c = 0; c < 4; c++) cycle(1, 0, 0);
    check("mr_pre_pc", pc_ID, 32'h0);
    @(posedge clk); #1; reset = 1'b1; #1;
    check("mr_rst_valid", {31'b0, valid_ID}, 32'd0);
    cycle(1, 0, 0);
    check("mr1_valid", {31'b0, valid_ID}, 32'd0);
    check("mr1_addr", imemAddr, 32'h0);
    check("mr1_req", {31'b0, imemReq}, 32'd1);
    cycle(1, 0, 0);
    check("mr2_valid", {31'b0, valid_ID}, 32'd0);
    cycle(0, 0, 0);
    check("mr3_pc", pc_ID, 32'h0);
    cycle(0, 0, 0);
    check("mr4_pc", pc_ID, 32'h8);

    // Address wrap-around past 0xFFFF_FFF8
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 1, 32'hFFFF_FFF0);
    cycle(0, 0, 0);
    check("wr_a0", imemAddr, 32'hFFFF_FFF0);
    cycle(0, 0, 0);
    check("wr_a1", imemAddr, 32'hFFFF_FFF8);
    cycle(0, 0, 0);
    check("wr_a2", imemAddr, 32'h0);
    check("wr_pc0", pc_ID, 32'hFFFF_FFF0);
    check("wr_i2", instr2_ID, 32'h0000_000F);
    cycle(0, 0, 0);
    check("wr_pc1", pc_ID, 32'hFFFF_FFF8);
    cycle(0, 0, 0);
    check("wr_pc2", pc_ID, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, minimum 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: fetch byte address loaded on reset; 8-byte aligned.
REQ-004 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port stall, input, 1: decode cannot accept the head pair this cycle.
REQ-007 Port branchTaken, input, 1: single-cycle redirect request.
REQ-008 Port branchTarget, input, 32: redirect byte address; bits[1:0] ignored.
REQ-009 Port imemReq, output, 1: fetch request to instruction memory.
REQ-010 Port imemAddr, output, 32: pair address; bits[2:0] always 0.
REQ-011 Port imemData, input, 64: pair returned exactly one cycle after the request; [63:32] is the even-slot instruction, [31:0] is the odd-slot instruction.
REQ-012 Port valid_ID, output, 1: head entry present.
REQ-013 Port instr1_ID, output, 32: head even-slot instruction.
REQ-014 Port instr2_ID, output, 32: head odd-slot instruction.
REQ-015 Port pc_ID, output, 32: head pair address.

Function
REQ-016 Fetch PC SHALL advance by 8 on every issued request, wrapping modulo 2^32.
REQ-017 imemReq SHALL be 1 only when all three hold: (occupancy + in-flight) < DEPTH; branchTaken=0; reset=0.
REQ-018 In-flight count SHALL be 0 or 1; a request issued in cycle k SHALL be written into the queue at the end of cycle k+1.
REQ-019 valid_ID SHALL rise in cycle k+2 for a request issued into an empty queue in cycle k.
REQ-020 A pop SHALL occur when valid_ID=1 and stall=0; the next entry SHALL be presented in the following cycle.
REQ-021 A simultaneous push and pop SHALL leave occupancy unchanged; FIFO order SHALL be preserved across pointer wrap-around.
REQ-022 The queue SHALL never overflow, because space is reserved at request time per REQ-017; a pop SHALL never occur when empty.
REQ-023 When valid_ID=0, instr1_ID, instr2_ID and pc_ID SHALL be 0.
REQ-024 On branchTaken=1 in cycle N, at the clock edge:
  - the queue SHALL be flushed;
  - any imemData returned in cycle N SHALL be discarded;
  - the fetch PC SHALL be loaded with {branchTarget[31:3],3'b000}.
REQ-025 The first request to the branch target SHALL issue in cycle N+1; valid_ID SHALL be 1 in cycle N+3.
REQ-026 If branchTarget[2]=1, the first pair fetched after the redirect SHALL have its even slot replaced by 32'h4020_0000 (nop) before it is written; later pairs SHALL be unmodified.
REQ-027 branchTaken SHALL take priority over a simultaneous pop, push or stall; the popped pair in that cycle is lost.
REQ-028 A branchTaken during a stall SHALL flush the queue identically to REQ-024.

Reset
REQ-029 While reset=1:
  - imemReq=0, valid_ID=0, instr1_ID=0, instr2_ID=0, pc_ID=0;
  - occupancy=0 and in-flight=0;
  - fetch PC=RESET_PC;
  - branchTaken SHALL be ignored.
REQ-030 imemData returned in the first cycle after reset deassertion SHALL be discarded.
REQ-031 Reset asserted mid-operation SHALL discard all entries and the in-flight request within one edge.
REQ-032 The first request after reset SHALL issue in the first cycle with reset=0, with imemAddr=RESET_PC.

Verification
REQ-033 Reset released at cycle 0, stall=0, memory returns {addr,~addr} -> requests at 0x0, 0x8, 0x10, ... one per cycle; valid_ID from cycle 2; pc_ID=0x0, then 0x8.
REQ-034 stall held at 1 from cycle 0 -> exactly 4 requests (0x0–0x18); imemReq=0 afterwards; head stays at pc 0x0; stall released -> pops resume in order and requests restart at 0x20 in the same cycle space frees.
REQ-035 Queue full with stall=1, then branchTaken with target 0x104 -> next cycle queue empty and imemAddr=0x100; two cycles later valid_ID=1, pc_ID=0x100, instr1_ID=32'h4020_0000, instr2_ID from memory.
REQ-036 branchTaken in the cycle a request's data returns, target 0x200 -> returned pair never appears on the outputs; first output pc_ID=0x200.
REQ-037 reset pulsed mid-stream with 3 entries queued -> valid_ID=0 the next cycle; fetch resumes at RESET_PC; no pre-reset pair is observed.
REQ-038 Start fetching at 0xFFFF_FFF0 -> request addresses sequence 0xFFFF_FFF0, 0xFFFF_FFF8, 0x0 with correct pc_ID order.
